msfsm_hb_pipeline: RTL

Parametrised chain of `STAGES` synchronous Mealy half-buffer controllers implementing a 4-phase Ri/Ao → Ro/Ai handshake pipeline. Each handshake event is a single-cycle pulse. This block is the generic successor to the hand-composed multi-FSM half-marked-graph controllers. It sits between a left producer channel and a right consumer channel of the event-based pipeline. It adds depth scaling, occupancy status, token counters and optional protocol checking.

---
 rtl/msfsm_pkg.sv | 26 ++
 rtl/msfsm_hb_cell.sv | 61 ++++++
 rtl/msfsm_hb_pipeline.sv | 101 ++++++++++
 3 files changed

// File: rtl/msfsm_pkg.sv
// rtl/msfsm_pkg.sv - event/cell types and level helpers for the half-buffer pipeline
package msfsm_pkg;

  localparam logic MSFSM_RST_LVL = 1'b0;

  typedef struct packed {
    logic plus;
    logic minus;
  } msfsm_ev_t;

  typedef struct packed {
    logic ri_lvl;
    logic ai_lvl;
    logic ro_lvl;
  } msfsm_cell_t;

  // Level seen this cycle: plus wins over minus, otherwise hold.
  function automatic logic msfsm_level_eff(msfsm_ev_t ev, logic lvl);
    return ev.plus ? 1'b1 : (ev.minus ? 1'b0 : lvl);
  endfunction

  function automatic logic msfsm_ev_bad(msfsm_ev_t ev, logic lvl);
    return (ev.plus & lvl) | (ev.minus & ~lvl) | (ev.plus & ev.minus);
  endfunction

endpackage

// File: rtl/msfsm_hb_cell.sv
// rtl/msfsm_hb_cell.sv - one Mealy half-buffer cell; MSFSM_PROTOCOL_CHECK_EN adds event checking
module msfsm_hb_cell
  import msfsm_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  msfsm_ev_t ri_i,
  input  msfsm_ev_t ai_i,
  output msfsm_ev_t ro_o,
  output msfsm_ev_t ao_o,
  output logic      ro_lvl_o
`ifdef MSFSM_PROTOCOL_CHECK_EN
  ,
  output logic      err_o
`endif
);

  msfsm_cell_t st_q, st_d;
  msfsm_ev_t   ri_ev, ai_ev;
  logic        ri_eff, ai_eff, fire_rise, fire_fall;

  assign ri_ev = rst_ni ? ri_i : '0;
  assign ai_ev = rst_ni ? ai_i : '0;

`ifdef MSFSM_PROTOCOL_CHECK_EN
  logic ri_bad, ai_bad;
  assign ri_bad = msfsm_ev_bad(ri_ev, st_q.ri_lvl);
  assign ai_bad = msfsm_ev_bad(ai_ev, st_q.ai_lvl);
  // An illegal event is dropped: the level simply keeps its registered value.
  assign ri_eff = ri_bad ? st_q.ri_lvl : msfsm_level_eff(ri_ev, st_q.ri_lvl);
  assign ai_eff = ai_bad ? st_q.ai_lvl : msfsm_level_eff(ai_ev, st_q.ai_lvl);
  assign err_o  = ri_bad | ai_bad;
`else
  assign ri_eff = msfsm_level_eff(ri_ev, st_q.ri_lvl);
  assign ai_eff = msfsm_level_eff(ai_ev, st_q.ai_lvl);
`endif

  assign fire_rise = rst_ni & ~st_q.ro_lvl & ri_eff & ~ai_eff;
  assign fire_fall = rst_ni & st_q.ro_lvl & ~ri_eff & ai_eff;

  assign ro_o     = '{plus: fire_rise, minus: fire_fall};
  assign ao_o     = '{plus: fire_rise, minus: fire_fall};
  assign ro_lvl_o = st_q.ro_lvl;

  always_comb begin
    st_d        = st_q;
    st_d.ri_lvl = ri_eff;
    st_d.ai_lvl = ai_eff;
    if (fire_rise)      st_d.ro_lvl = 1'b1;
    else if (fire_fall) st_d.ro_lvl = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q <= '{ri_lvl: MSFSM_RST_LVL, ai_lvl: MSFSM_RST_LVL, ro_lvl: MSFSM_RST_LVL};
    end else begin
      st_q <= st_d;
    end
  end

endmodule

// File: rtl/msfsm_hb_pipeline.sv
// rtl/msfsm_hb_pipeline.sv - STAGES-deep chain of half-buffer cells; MSFSM_PROTOCOL_CHECK_EN enables proto_err
module msfsm_hb_pipeline
  import msfsm_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Ri_PLUS,
  input  logic              Ri_MINUS,
  input  logic              Ai_PLUS,
  input  logic              Ai_MINUS,
  output logic              Ro_PLUS,
  output logic              Ro_MINUS,
  output logic              Ao_PLUS,
  output logic              Ao_MINUS,
  output logic [STAGES-1:0] stage_ro,
  output logic [CNT_W-1:0]  tokens_in,
  output logic [CNT_W-1:0]  tokens_out,
  output logic              proto_err
);

  msfsm_ev_t ri_w [STAGES];
  msfsm_ev_t ai_w [STAGES];
  msfsm_ev_t ro_w [STAGES];
  msfsm_ev_t ao_w [STAGES];
`ifdef MSFSM_PROTOCOL_CHECK_EN
  logic [STAGES-1:0] err_w;
`endif
  logic [CNT_W-1:0] tokens_in_q, tokens_out_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_cell
    if (k == 0) begin : g_left
      assign ri_w[k] = '{plus: Ri_PLUS, minus: Ri_MINUS};
    end else begin : g_fwd
      // One register per hop keeps the logic depth to a single cell.
      msfsm_ev_t fwd_q;
      always_ff @(posedge clk) begin
        if (!reset) fwd_q <= '0;
        else        fwd_q <= ro_w[k-1];
      end
      assign ri_w[k] = fwd_q;
    end

    if (k == STAGES - 1) begin : g_right
      assign ai_w[k] = '{plus: Ai_PLUS, minus: Ai_MINUS};
    end else begin : g_bwd
      msfsm_ev_t bwd_q;
      always_ff @(posedge clk) begin
        if (!reset) bwd_q <= '0;
        else        bwd_q <= ao_w[k+1];
      end
      assign ai_w[k] = bwd_q;
    end

    msfsm_hb_cell u_cell (
      .clk_i    (clk),
      .rst_ni   (reset),
      .ri_i     (ri_w[k]),
      .ai_i     (ai_w[k]),
      .ro_o     (ro_w[k]),
      .ao_o     (ao_w[k]),
      .ro_lvl_o (stage_ro[k])
`ifdef MSFSM_PROTOCOL_CHECK_EN
      ,
      .err_o    (err_w[k])
`endif
    );
  end

  assign Ao_PLUS  = ao_w[0].plus;
  assign Ao_MINUS = ao_w[0].minus;
  assign Ro_PLUS  = ro_w[STAGES-1].plus;
  assign Ro_MINUS = ro_w[STAGES-1].minus;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tokens_in_q  <= '0;
      tokens_out_q <= '0;
    end else begin
      if (Ao_PLUS) tokens_in_q  <= tokens_in_q + CNT_W'(1);
      if (Ro_PLUS) tokens_out_q <= tokens_out_q + CNT_W'(1);
    end
  end

  assign tokens_in  = tokens_in_q;
  assign tokens_out = tokens_out_q;

`ifdef MSFSM_PROTOCOL_CHECK_EN
  logic proto_err_q;
  always_ff @(posedge clk) begin
    if (!reset)      proto_err_q <= 1'b0;
    else if (|err_w) proto_err_q <= 1'b1;
  end
  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule
